// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- bundles the control/data bus of the PC sequencer.
//   master : drives update controls and target sources, observes PC and RAS status
//   slave  : the sequencer itself
// Signals: pc_write, pc_src[2:0], imm_addr, se_imm_addr, ra, mary, comp, call,
//          ret (to sequencer); pc_out, branch_taken, ras_empty, ras_full,
//          ras_overflow, ras_underflow (from sequencer).
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             pc_write;
  logic [2:0]       pc_src;
  logic [WIDTH-1:0] imm_addr;
  logic [WIDTH-1:0] se_imm_addr;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] mary;
  logic             comp;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic             branch_taken;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output pc_write, pc_src, imm_addr, se_imm_addr, ra, mary, comp, call, ret,
    input  pc_out, branch_taken, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  pc_write, pc_src, imm_addr, se_imm_addr, ra, mary, comp, call, ret,
    output pc_out, branch_taken, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter with next-PC select and a circular
// return-address stack (RAS).
// Ports:
//   clock : single clock, rising edge
//   reset : synchronous active-high reset, overrides everything
//   bus   : pc_sequencer_if.slave (update controls in; PC, branch pulse and
//           RAS status flags out, all registered)
module pc_sequencer #(
  parameter int               WIDTH      = 16,
  parameter int               RAS_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int               MARY_SHIFT = 4
) (
  input  logic         clock,
  input  logic         reset,
  pc_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // ptr_reg is the next free slot; the top of stack sits one below it.
  logic [WIDTH-1:0] pc_reg;
  logic             branch_taken_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             underflow_reg;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] pc_next;
  logic             branch_taken_next;
  logic [PTR_W-1:0] ptr_next;
  logic [CNT_W-1:0] count_next;
  logic             overflow_next;
  logic             underflow_next;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             do_push;
  logic             do_pop;
  logic             ras_nonempty;
  logic             ras_is_full;

  always_comb begin
    pc_plus1     = pc_reg + WIDTH'(1);
    ras_top      = ras_mem[ptr_reg - PTR_W'(1)];
    ras_nonempty = (count_reg != '0);
    ras_is_full  = (count_reg == CNT_FULL);
    do_push      = bus.call;
    // ret only has meaning in the return mode
    do_pop       = bus.ret && (bus.pc_src == 3'b011);

    pc_next = pc_plus1;
    case (bus.pc_src)
      3'b000: pc_next = pc_plus1;
      3'b001: pc_next = pc_reg + bus.se_imm_addr;
      3'b010: pc_next = bus.imm_addr;
      3'b011: pc_next = (bus.ret && ras_nonempty) ? ras_top : bus.ra;
      3'b100: pc_next = bus.mary;
      3'b101: pc_next = pc_reg + (bus.mary << MARY_SHIFT);
      3'b110: pc_next = bus.comp ? bus.imm_addr : pc_plus1;
      3'b111: pc_next = bus.comp ? (pc_reg + bus.se_imm_addr) : pc_plus1;
      default: pc_next = pc_plus1;
    endcase
    branch_taken_next = (bus.pc_src[2:1] == 2'b11) && bus.comp;

    ptr_next       = ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    wr_en          = 1'b0;
    wr_idx         = ptr_reg;

    if (do_push && do_pop) begin
      if (ras_nonempty) begin
        // net pop-then-push: overwrite the top in place
        wr_en  = 1'b1;
        wr_idx = ptr_reg - PTR_W'(1);
      end else begin
        // nothing to pop: degenerate to a plain push, flag the bad pop
        wr_en          = 1'b1;
        wr_idx         = ptr_reg;
        ptr_next       = ptr_reg + PTR_W'(1);
        count_next     = CNT_W'(1);
        underflow_next = 1'b1;
      end
    end else if (do_push) begin
      wr_en    = 1'b1;
      wr_idx   = ptr_reg;
      ptr_next = ptr_reg + PTR_W'(1);
      // when full, ptr_reg already addresses the oldest entry, so the write
      // overwrites it and the count stays saturated
      if (ras_is_full) begin
        overflow_next = 1'b1;
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end else if (do_pop) begin
      if (ras_nonempty) begin
        ptr_next   = ptr_reg - PTR_W'(1);
        count_next = count_reg - CNT_W'(1);
      end else begin
        underflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg           <= RESET_PC;
      branch_taken_reg <= 1'b0;
      ptr_reg          <= '0;
      count_reg        <= '0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else if (bus.pc_write) begin
      pc_reg           <= pc_next;
      branch_taken_reg <= branch_taken_next;
      ptr_reg          <= ptr_next;
      count_reg        <= count_next;
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
    end else begin
      // stall: everything holds, but the taken pulse must not stretch
      branch_taken_reg <= 1'b0;
    end
  end

  // Entry storage is not reset; only the pointer and count define validity.
  always_ff @(posedge clock) begin
    if (!reset && bus.pc_write && wr_en) begin
      ras_mem[wr_idx] <= pc_plus1;
    end
  end

  assign bus.pc_out        = pc_reg;
  assign bus.branch_taken  = branch_taken_reg;
  assign bus.ras_empty     = (count_reg == '0);
  assign bus.ras_full      = (count_reg == CNT_FULL);
  assign bus.ras_overflow  = overflow_reg;
  assign bus.ras_underflow = underflow_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- scoreboard bench for pc_sequencer (WIDTH=16, RAS_DEPTH=4).
// Each transaction is driven on the falling edge, the reference model's
// expected state is queued, and it is popped and compared after the next
// rising edge.
module tb_pc_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  pc_sequencer_if #(.WIDTH(16)) bus ();

  pc_sequencer #(
    .WIDTH(16), .RAS_DEPTH(4), .RESET_PC(16'h0000), .MARY_SHIFT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] pc;
    logic        bt;
    logic        emp;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_stack[$];
  logic        m_bt = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_step(input logic rst, input logic pw, input logic [2:0] src,
                            input logic [15:0] imm, input logic [15:0] se,
                            input logic [15:0] ra_v, input logic [15:0] mary_v,
                            input logic cmp, input logic cl, input logic rt);
    logic [15:0] seq;
    logic [15:0] tgt;
    logic [15:0] scaled;
    exp_t e;
    if (rst) begin
      m_pc = 16'h0000;
      m_stack.delete();
      m_bt = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!pw) begin
      m_bt = 1'b0;
    end else begin
      seq = m_pc + 16'd1;
      scaled = mary_v << 4;
      case (src)
        3'd0: tgt = seq;
        3'd1: tgt = m_pc + se;
        3'd2: tgt = imm;
        3'd3: tgt = (rt && m_stack.size() > 0) ? m_stack[$] : ra_v;
        3'd4: tgt = mary_v;
        3'd5: tgt = m_pc + scaled;
        3'd6: tgt = cmp ? imm : seq;
        default: tgt = cmp ? (m_pc + se) : seq;
      endcase
      if (rt && src == 3'd3) begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else m_unf = 1'b1;
      end
      if (cl) begin
        if (m_stack.size() == 4) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_stack.push_back(seq);
      end
      m_bt = (src == 3'd6 || src == 3'd7) && cmp;
      m_pc = tgt;
    end
    e.pc = m_pc;
    e.bt = m_bt;
    e.emp = (m_stack.size() == 0);
    e.full = (m_stack.size() == 4);
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic pw, input logic [2:0] src,
                       input logic [15:0] imm, input logic [15:0] se,
                       input logic [15:0] ra_v, input logic [15:0] mary_v,
                       input logic cmp, input logic cl, input logic rt);
    exp_t e;
    @(negedge clock);
    reset = rst;
    bus.pc_write = pw;
    bus.pc_src = src;
    bus.imm_addr = imm;
    bus.se_imm_addr = se;
    bus.ra = ra_v;
    bus.mary = mary_v;
    bus.comp = cmp;
    bus.call = cl;
    bus.ret = rt;
    model_step(rst, pw, src, imm, se, ra_v, mary_v, cmp, cl, rt);
    @(posedge clock);
    #1;
    n_txn++;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      $display("txn %0d rst=%0b pw=%0b src=%0d call=%0b ret=%0b -> pc=%04h bt=%0b emp=%0b full=%0b ovf=%0b unf=%0b",
               n_txn, rst, pw, src, cl, rt, bus.pc_out, bus.branch_taken,
               bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow);
      check("pc_out", 32'(bus.pc_out), 32'(e.pc));
      check("branch_taken", 32'(bus.branch_taken), 32'(e.bt));
      check("ras_empty", 32'(bus.ras_empty), 32'(e.emp));
      check("ras_full", 32'(bus.ras_full), 32'(e.full));
      check("ras_overflow", 32'(bus.ras_overflow), 32'(e.ovf));
      check("ras_underflow", 32'(bus.ras_underflow), 32'(e.unf));
    end
  endtask

  // shorthand: normal update with selectable mode and controls
  task automatic upd(input logic [2:0] src, input logic [15:0] imm, input logic [15:0] se,
                     input logic [15:0] ra_v, input logic [15:0] mary_v,
                     input logic cmp, input logic cl, input logic rt);
    drive(1'b0, 1'b1, src, imm, se, ra_v, mary_v, cmp, cl, rt);
  endtask

  task automatic preload(input logic [15:0] v);
    upd(3'd2, v, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic cl);
    drive(1'b1, 1'b1, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, cl, 1'b0);
  endtask

  initial begin
    bus.pc_write = 1'b0;
    bus.pc_src = 3'd0;
    bus.imm_addr = '0;
    bus.se_imm_addr = '0;
    bus.ra = '0;
    bus.mary = '0;
    bus.comp = 1'b0;
    bus.call = 1'b0;
    bus.ret = 1'b0;

    // reset state and sequential counting with wrap
    do_reset(1'b0);
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) upd(3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    preload(16'hFFFF);
    upd(3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    // conditional branches: taken pulse lasts one cycle, not-taken falls through
    preload(16'h0010);
    upd(3'd7, 16'h0, 16'hFFFC, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    upd(3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    preload(16'h0010);
    upd(3'd7, 16'h0, 16'hFFFC, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    upd(3'd6, 16'h0040, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    upd(3'd6, 16'h0080, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    upd(3'd1, 16'h0, 16'h0010, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    upd(3'd4, 16'h0, 16'h0, 16'h0, 16'h1234, 1'b0, 1'b0, 1'b0);

    // call / return
    preload(16'h0020);
    upd(3'd2, 16'h0100, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    upd(3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);  // ret ignored outside 011
    upd(3'd3, 16'h0, 16'h0, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b1);
    upd(3'd3, 16'h0, 16'h0, 16'h0777, 16'h0, 1'b0, 1'b0, 1'b0);  // ret=0 -> ra

    // overflow: 5 calls, then 4 good pops and one underflowing pop
    for (int i = 0; i < 5; i++) upd(3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) upd(3'd3, 16'h0, 16'h0, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b1);

    // replace-top, non-empty and empty
    do_reset(1'b0);
    upd(3'd2, 16'h0200, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    upd(3'd3, 16'h0, 16'h0, 16'hBEEF, 16'h0, 1'b0, 1'b1, 1'b1);
    upd(3'd3, 16'h0, 16'h0, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b1);
    do_reset(1'b0);
    upd(3'd3, 16'h0, 16'h0, 16'h0077, 16'h0, 1'b0, 1'b1, 1'b1);
    upd(3'd3, 16'h0, 16'h0, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b1);

    // stall holds PC and RAS, and kills a pending taken pulse
    preload(16'h0030);
    drive(1'b0, 1'b0, 3'd2, 16'h5555, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    upd(3'd6, 16'h0400, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd6, 16'h0500, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    // reset with a concurrent call discards the push and clears flags
    for (int i = 0; i < 5; i++) upd(3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    do_reset(1'b1);

    // scaled-relative mode including discarded high bits
    preload(16'h0004);
    upd(3'd5, 16'h0, 16'h0, 16'h0, 16'h0003, 1'b0, 1'b0, 1'b0);
    preload(16'h0004);
    upd(3'd5, 16'h0, 16'h0, 16'h0, 16'h1000, 1'b0, 1'b0, 1'b0);

    // randomized tail against the model
    for (int i = 0; i < 60; i++) begin
      upd(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
          16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
